// File: rtl/memory_stage_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
// State encoding, datapath widths and the captured-instruction record.
package memory_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  // Fields of the accepted memory op that must survive until the access completes.
  typedef struct packed {
    logic [REG_W-1:0]  regdest;
    logic              writereg;
    logic              selwsource;
    logic [DATA_W-1:0] wbvalue;
  } mem_capture_t;

  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Wait-cycle counter for the memory stage; flags the last permitted WAIT cycle.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST_COUNT);

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory-access stage: issues loads/stores over a req/ack port,
// stalls upstream while waiting, and registers the writeback bundle.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [DATA_W-1:0] ex_mem_regb,
  input  logic              ex_mem_selwsource,
  input  logic [REG_W-1:0]  ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [DATA_W-1:0] ex_mem_wbvalue,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_ex_stall,
  output logic [REG_W-1:0]  mem_wb_regdest,
  output logic              mem_wb_writereg,
  output logic [DATA_W-1:0] mem_wb_wbvalue,
  output logic              mem_buserr,
  output logic              mem_misalign
);

  logic [1:0]   state;
  mem_capture_t captured;
  logic         timer_expired;
  logic         is_mem_op;
  logic         reject_op;

  assign is_mem_op = ex_mem_readmem | ex_mem_writemem;

`ifdef MEM_ALIGN_CHECK_EN
  assign reject_op = is_mem_op && is_misaligned(ex_mem_wbvalue);
`else
  assign reject_op = 1'b0;
`endif

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != S_WAIT),
    .enable  ((state == S_WAIT) && !dmem_ack),
    .expired (timer_expired)
  );

  // Ack takes priority over expiry so a late-but-valid response is never discarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      captured        <= '0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      mem_ex_stall    <= 1'b0;
      mem_wb_regdest  <= '0;
      mem_wb_writereg <= 1'b0;
      mem_wb_wbvalue  <= '0;
      mem_buserr      <= 1'b0;
    end else begin
      mem_buserr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reject_op) begin
            mem_wb_writereg <= 1'b0;
          end else if (is_mem_op) begin
            captured.regdest    <= ex_mem_regdest;
            captured.writereg   <= ex_mem_writereg;
            captured.selwsource <= ex_mem_selwsource;
            captured.wbvalue    <= ex_mem_wbvalue;
            dmem_req            <= 1'b1;
            dmem_we             <= ex_mem_writemem;
            dmem_addr           <= ex_mem_wbvalue;
            dmem_wdata          <= ex_mem_regb;
            mem_ex_stall        <= 1'b1;
            mem_wb_writereg     <= 1'b0;
            state               <= S_WAIT;
          end else begin
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            mem_wb_wbvalue  <= ex_mem_wbvalue;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req        <= 1'b0;
            mem_ex_stall    <= 1'b0;
            mem_wb_regdest  <= captured.regdest;
            mem_wb_writereg <= captured.writereg;
            mem_wb_wbvalue  <= captured.selwsource ? dmem_rdata : captured.wbvalue;
            state           <= S_IDLE;
          end else if (timer_expired) begin
            dmem_req        <= 1'b0;
            mem_ex_stall    <= 1'b0;
            mem_buserr      <= 1'b1;
            mem_wb_writereg <= 1'b0;
            state           <= S_IDLE;
          end else begin
            mem_wb_writereg <= 1'b0;
          end
        end
        default: begin
          dmem_req        <= 1'b0;
          mem_ex_stall    <= 1'b0;
          mem_wb_writereg <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_misalign <= 1'b0;
    end else begin
      mem_misalign <= (state == S_IDLE) && reject_op;
    end
  end
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT_CYCLES = 4).
// Exercises passthrough, load/store handshakes, timeout, misalign and async reset.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_mem_readmem = 1'b0;
  logic        ex_mem_writemem = 1'b0;
  logic [31:0] ex_mem_regb = '0;
  logic        ex_mem_selwsource = 1'b0;
  logic [4:0]  ex_mem_regdest = '0;
  logic        ex_mem_writereg = 1'b0;
  logic [31:0] ex_mem_wbvalue = '0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        mem_ex_stall;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;
  logic        mem_buserr;
  logic        mem_misalign;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleCount;

  memory_stage #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (5)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ex_mem_readmem    (ex_mem_readmem),
    .ex_mem_writemem   (ex_mem_writemem),
    .ex_mem_regb       (ex_mem_regb),
    .ex_mem_selwsource (ex_mem_selwsource),
    .ex_mem_regdest    (ex_mem_regdest),
    .ex_mem_writereg   (ex_mem_writereg),
    .ex_mem_wbvalue    (ex_mem_wbvalue),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .mem_ex_stall      (mem_ex_stall),
    .mem_wb_regdest    (mem_wb_regdest),
    .mem_wb_writereg   (mem_wb_writereg),
    .mem_wb_wbvalue    (mem_wb_wbvalue),
    .mem_buserr        (mem_buserr),
    .mem_misalign      (mem_misalign)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] regb,
                               input logic selw, input logic [4:0] rdest,
                               input logic wreg, input logic [31:0] wbval);
    ex_mem_readmem    = rd;
    ex_mem_writemem   = wr;
    ex_mem_regb       = regb;
    ex_mem_selwsource = selw;
    ex_mem_regdest    = rdest;
    ex_mem_writereg   = wreg;
    ex_mem_wbvalue    = wbval;
  endtask

  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    nextEdge();
    nextEdge();
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, mem_ex_stall}, 32'd0);
    checkOutput("rst_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    checkOutput("rst_wbvalue", mem_wb_wbvalue, 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // ALU passthrough
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0000_1234);
    nextEdge();
    checkOutput("alu_wbvalue", mem_wb_wbvalue, 32'h0000_1234);
    checkOutput("alu_regdest", {27'd0, mem_wb_regdest}, 32'd5);
    checkOutput("alu_writereg", {31'd0, mem_wb_writereg}, 32'd1);
    checkOutput("alu_stall", {31'd0, mem_ex_stall}, 32'd0);

    // Load, ack in the third WAIT cycle
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd8, 1'b1, 32'h0000_0100);
    nextEdge();
    checkOutput("ld_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("ld_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("ld_addr", dmem_addr, 32'h0000_0100);
    checkOutput("ld_bubble", {31'd0, mem_wb_writereg}, 32'd0);
    checkOutput("ld_wb_retained", mem_wb_wbvalue, 32'h0000_1234);
    cycleCount = mem_ex_stall ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      nextEdge();
      if (mem_ex_stall) cycleCount++;
      checkOutput("ld_addr_held", dmem_addr, 32'h0000_0100);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    nextEdge();
    dmem_ack = 1'b0;
    checkOutput("ld_stall_cycles", cycleCount, 32'd3);
    checkOutput("ld_done_stall", {31'd0, mem_ex_stall}, 32'd0);
    checkOutput("ld_done_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("ld_wbvalue", mem_wb_wbvalue, 32'hDEAD_BEEF);
    checkOutput("ld_regdest", {27'd0, mem_wb_regdest}, 32'd8);
    checkOutput("ld_writereg", {31'd0, mem_wb_writereg}, 32'd1);

    // Store with immediate ack
    applyStimulus(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 5'd3, 1'b0, 32'h0000_0200);
    dmem_ack = 1'b1;
    nextEdge();
    checkOutput("st_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("st_we", {31'd0, dmem_we}, 32'd1);
    checkOutput("st_wdata", dmem_wdata, 32'hCAFE_0001);
    checkOutput("st_addr", dmem_addr, 32'h0000_0200);
    nextEdge();
    checkOutput("st_done_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("st_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    checkOutput("st_wbvalue", mem_wb_wbvalue, 32'h0000_0200);

    // Both readmem and writemem behave as a store
    applyStimulus(1'b1, 1'b1, 32'h0000_0077, 1'b0, 5'd4, 1'b0, 32'h0000_0204);
    nextEdge();
    checkOutput("both_we", {31'd0, dmem_we}, 32'd1);
    nextEdge();
    checkOutput("both_done_req", {31'd0, dmem_req}, 32'd0);

    // Stray ack while IDLE leaves a passthrough untouched
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd2, 1'b1, 32'h0000_00AB);
    nextEdge();
    dmem_ack = 1'b0;
    checkOutput("idle_ack_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("idle_ack_wb", mem_wb_wbvalue, 32'h0000_00AB);

    // Timeout: request held exactly four cycles, then bus error
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 32'h0000_0300);
    nextEdge();
    cycleCount = dmem_req ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      nextEdge();
      if (!dmem_req) break;
      cycleCount++;
    end
    checkOutput("to_req_cycles", cycleCount, 32'd4);
    checkOutput("to_buserr", {31'd0, mem_buserr}, 32'd1);
    checkOutput("to_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    checkOutput("to_stall", {31'd0, mem_ex_stall}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd10, 1'b1, 32'h0000_0055);
    nextEdge();
    checkOutput("to_buserr_pulse", {31'd0, mem_buserr}, 32'd0);
    checkOutput("to_next_wb", mem_wb_wbvalue, 32'h0000_0055);
    checkOutput("to_next_writereg", {31'd0, mem_wb_writereg}, 32'd1);

    // Ack in the timeout cycle wins
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd11, 1'b1, 32'h0000_0400);
    nextEdge();
    nextEdge();
    nextEdge();
    nextEdge();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    nextEdge();
    dmem_ack = 1'b0;
    checkOutput("ackwin_buserr", {31'd0, mem_buserr}, 32'd0);
    checkOutput("ackwin_writereg", {31'd0, mem_wb_writereg}, 32'd1);
    checkOutput("ackwin_wbvalue", mem_wb_wbvalue, 32'h0BAD_F00D);

    // Misaligned load
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd12, 1'b1, 32'h0000_0102);
    nextEdge();
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("mis_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("mis_pulse", {31'd0, mem_misalign}, 32'd1);
    checkOutput("mis_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    nextEdge();
    checkOutput("mis_pulse_end", {31'd0, mem_misalign}, 32'd0);
    checkOutput("mis_req_after", {31'd0, dmem_req}, 32'd0);
`else
    checkOutput("mis_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("mis_addr", dmem_addr, 32'h0000_0102);
    checkOutput("mis_flag", {31'd0, mem_misalign}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    dmem_ack = 1'b1;
    nextEdge();
    dmem_ack = 1'b0;
    checkOutput("mis_done_req", {31'd0, dmem_req}, 32'd0);
`endif

    // Reset in the middle of WAIT
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd13, 1'b1, 32'h0000_0500);
    nextEdge();
    checkOutput("rw_req_before", {31'd0, dmem_req}, 32'd1);
    nextEdge();
    reset = 1'b0;
    #1;
    checkOutput("rw_req_async", {31'd0, dmem_req}, 32'd0);
    checkOutput("rw_stall_async", {31'd0, mem_ex_stall}, 32'd0);
    checkOutput("rw_addr", dmem_addr, 32'd0);
    checkOutput("rw_wbvalue", mem_wb_wbvalue, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_2222;
    @(negedge clock);
    reset = 1'b1;
    nextEdge();
    checkOutput("rw_no_wb", {31'd0, mem_wb_writereg}, 32'd0);
    checkOutput("rw_no_wbvalue", mem_wb_wbvalue, 32'd0);
    nextEdge();
    checkOutput("rw_no_req", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
